// File: rtl/core_pkg.sv
// Shared core definitions: stage indices, core stage count and the one-hot
// stage vector type used by the stage sequencer and its neighbours.
package core_pkg;

  localparam int STAGE_FETCH      = 0;
  localparam int STAGE_DECODE     = 1;
  localparam int STAGE_READ       = 2;
  localparam int STAGE_EXECUTE    = 3;
  localparam int STAGE_MEMORY     = 4;
  localparam int STAGE_WRITE_BACK = 5;

  localparam int NUM_CORE_STAGES  = 6;

  typedef logic [NUM_CORE_STAGES-1:0] stage_onehot_t;

  // Stages that stretch while memory is not ready: FETCH and MEMORY (6'h11).
  localparam stage_onehot_t DEFAULT_WAIT_MASK =
    stage_onehot_t'((32'd1 << STAGE_FETCH) | (32'd1 << STAGE_MEMORY));

endpackage

// File: rtl/stage_sequencer_if.sv
// Handshake bundle between decode/datapath and the stage sequencer.
// master: the core side that supplies skip/wait/fault and consumes stage outputs.
// slave : the sequencer itself.
// Performance counter signals exist only when STAGE_SEQ_PERF_EN is defined.
interface stage_sequencer_if
  import core_pkg::*;
#(
  parameter int NUM_STAGES = NUM_CORE_STAGES
`ifdef STAGE_SEQ_PERF_EN
  , parameter int COUNT_W  = 32
`endif
);

  logic [NUM_STAGES-1:0] skip_mask;
  logic                  mem_wait;
  logic                  fault_in;
  logic [NUM_STAGES-1:0] stage;
  logic [NUM_STAGES-1:0] stage_en;
  logic                  retire;
  logic                  halted;
`ifdef STAGE_SEQ_PERF_EN
  logic [COUNT_W-1:0]    cycle_count;
  logic [COUNT_W-1:0]    retire_count;
`endif

`ifdef STAGE_SEQ_PERF_EN
  modport master (
    output skip_mask, mem_wait, fault_in,
    input  stage, stage_en, retire, halted, cycle_count, retire_count
  );
  modport slave (
    input  skip_mask, mem_wait, fault_in,
    output stage, stage_en, retire, halted, cycle_count, retire_count
  );
`else
  modport master (
    output skip_mask, mem_wait, fault_in,
    input  stage, stage_en, retire, halted
  );
  modport slave (
    input  skip_mask, mem_wait, fault_in,
    output stage, stage_en, retire, halted
  );
`endif

endinterface

// File: rtl/stage_sequencer_next_pick.sv
// stage_next_pick: combinational next-stage selector. Starting just after the
// current one-hot position it walks the ring (rotate) and returns the first
// stage whose skip bit is clear (priority find), wrapping past the top.
// Kept standalone so a formal harness can bind to it directly.
module stage_next_pick #(
  parameter int N = 6
) (
  input  logic [N-1:0] cur,
  input  logic [N-1:0] skip,
  output logic [N-1:0] next
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] tgt;
  logic             found;

  // Rotate from the current position and take the first non-skipped stage.
  always_comb begin
    next  = '0;
    found = 1'b0;
    tgt   = '0;
    for (int j = 0; j < N; j++) begin
      if (cur[j]) begin
        for (int k = 1; k < N; k++) begin
          tgt = IDX_W'((j + k) % N);
          if (!found && !skip[tgt]) begin
            next[tgt] = 1'b1;
            found     = 1'b1;
          end else begin
          end
        end
      end else begin
      end
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: parametrised one-hot stage controller for the multi-cycle
// core. Walks FETCH..WRITE_BACK with per-instruction skipping, wait-state
// holds on selected stages, a sticky fault halt and a retire pulse.
// Optional build macro STAGE_SEQ_PERF_EN adds cycle/retire counters.
module stage_sequencer
  import core_pkg::*;
#(
  parameter int                    NUM_STAGES = NUM_CORE_STAGES,
  parameter int                    DECODE_IDX = STAGE_DECODE,
  parameter logic [NUM_STAGES-1:0] WAIT_MASK  = DEFAULT_WAIT_MASK
`ifdef STAGE_SEQ_PERF_EN
  , parameter int                  COUNT_W    = 32
`endif
) (
  input  logic            clk,
  input  logic            reset,
  stage_sequencer_if.slave bus
);

  localparam int LAST_IDX = NUM_STAGES - 1;
  localparam logic [NUM_STAGES-1:0] FIRST_STAGE = {{(NUM_STAGES-1){1'b0}}, 1'b1};

  logic [NUM_STAGES-1:0] cur_stage;
  logic [NUM_STAGES-1:0] cur_en;
  logic                  retire_pulse;
  logic                  halt_flag;
  logic [NUM_STAGES-1:0] held_skip;
  // Set on the edge a stage is entered; enables the single stage_en pulse.
  logic                  fresh;

  logic [NUM_STAGES-1:0] keep_mask;
  logic [NUM_STAGES-1:0] skip_src;
  logic [NUM_STAGES-1:0] eff_skip;
  logic [NUM_STAGES-1:0] next_stage;
  logic                  wait_hold;
  logic                  advance;

  // Stages up to decode and the last stage can never be bypassed.
  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      keep_mask[i] = (i <= DECODE_IDX) || (i == LAST_IDX);
    end
  end

  // Hold/advance decision and the skip mask in force for this step.
  always_comb begin
    wait_hold = bus.mem_wait && (|(cur_stage & WAIT_MASK));
    // While in decode the live mask steers the very first jump.
    skip_src  = cur_stage[DECODE_IDX] ? bus.skip_mask : held_skip;
    eff_skip  = skip_src & ~keep_mask;
    advance   = !halt_flag && !bus.fault_in && (cur_stage != '0) && !wait_hold;
  end

  stage_next_pick #(
    .N (NUM_STAGES)
  ) u_next_pick (
    .cur  (cur_stage),
    .skip (eff_skip),
    .next (next_stage)
  );

  // Stage ring state: reset, fault halt, idle start, advance or hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_stage    <= '0;
      cur_en       <= '0;
      retire_pulse <= 1'b0;
      halt_flag    <= 1'b0;
      held_skip    <= '0;
      fresh        <= 1'b0;
    end else if (bus.fault_in || halt_flag) begin
      cur_stage    <= '0;
      cur_en       <= '0;
      retire_pulse <= 1'b0;
      halt_flag    <= 1'b1;
      held_skip    <= '0;
      fresh        <= 1'b0;
    end else if (cur_stage == '0) begin
      cur_stage    <= FIRST_STAGE;
      cur_en       <= '0;
      retire_pulse <= 1'b0;
      fresh        <= 1'b1;
    end else if (advance) begin
      cur_stage    <= next_stage;
      cur_en       <= fresh ? cur_stage : '0;
      retire_pulse <= cur_stage[LAST_IDX];
      fresh        <= 1'b1;
      if (cur_stage[DECODE_IDX]) begin
        held_skip <= bus.skip_mask;
      end else if (cur_stage[LAST_IDX]) begin
        held_skip <= '0;
      end else begin
        held_skip <= held_skip;
      end
    end else begin
      // Wait-state dwell: the entry pulse fires once, then stays low.
      cur_en       <= fresh ? cur_stage : '0;
      retire_pulse <= 1'b0;
      fresh        <= 1'b0;
    end
  end

  assign bus.stage    = cur_stage;
  assign bus.stage_en = cur_en;
  assign bus.retire   = retire_pulse;
  assign bus.halted   = halt_flag;

`ifdef STAGE_SEQ_PERF_EN
  logic [COUNT_W-1:0] cycles;
  logic [COUNT_W-1:0] retires;

  // Free-running performance counters, frozen while halted, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycles  <= '0;
      retires <= '0;
    end else begin
      if (!halt_flag) begin
        cycles <= cycles + COUNT_W'(1);
      end else begin
        cycles <= cycles;
      end
      if (advance && cur_stage[LAST_IDX]) begin
        retires <= retires + COUNT_W'(1);
      end else begin
        retires <= retires;
      end
    end
  end

  assign bus.cycle_count  = cycles;
  assign bus.retire_count = retires;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed self-checking bench for stage_sequencer (6 stages, decode at 1,
// wait on FETCH/MEMORY). With STAGE_SEQ_PERF_EN the counters use COUNT_W=4.
module tb_stage_sequencer;
  import core_pkg::*;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

`ifdef STAGE_SEQ_PERF_EN
  logic [3:0] cc_m;
  logic [3:0] rc_m;
  logic       halt_m;
`endif

  stage_sequencer_if #(
    .NUM_STAGES (NUM_CORE_STAGES)
`ifdef STAGE_SEQ_PERF_EN
    , .COUNT_W  (4)
`endif
  ) bus ();

  stage_sequencer #(
    .NUM_STAGES (NUM_CORE_STAGES),
    .DECODE_IDX (STAGE_DECODE),
    .WAIT_MASK  (DEFAULT_WAIT_MASK)
`ifdef STAGE_SEQ_PERF_EN
    , .COUNT_W  (4)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then compare all outputs half a cycle later.
  task automatic step(input string tag, input logic [5:0] es, input logic [5:0] een,
                      input logic er, input logic eh);
`ifdef STAGE_SEQ_PERF_EN
    if (reset) begin
      cc_m = 4'd0;
      rc_m = 4'd0;
    end else begin
      if (!halt_m) cc_m = cc_m + 4'd1;
      if (er)      rc_m = rc_m + 4'd1;
    end
    halt_m = eh;
`endif
    @(posedge clk);
    @(negedge clk);
    check({tag, ".stage"},    32'(bus.stage),    32'(es));
    check({tag, ".stage_en"}, 32'(bus.stage_en), 32'(een));
    check({tag, ".retire"},   32'(bus.retire),   32'(er));
    check({tag, ".halted"},   32'(bus.halted),   32'(eh));
`ifdef STAGE_SEQ_PERF_EN
    check({tag, ".cycle_count"},  32'(bus.cycle_count),  32'(cc_m));
    check({tag, ".retire_count"}, 32'(bus.retire_count), 32'(rc_m));
`endif
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
`ifdef STAGE_SEQ_PERF_EN
    cc_m   = 4'd0;
    rc_m   = 4'd0;
    halt_m = 1'b0;
`endif
    reset         = 1'b1;
    bus.skip_mask = 6'b000000;
    bus.mem_wait  = 1'b0;
    bus.fault_in  = 1'b0;
    @(negedge clk);

    // Reset state over two cycles.
    step("rst0", 6'd0, 6'd0, 1'b0, 1'b0);
    step("rst1", 6'd0, 6'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // Plain ring walk; stage_en lags one cycle, retire after WRITE_BACK.
    step("t1_e1", 6'd1,  6'd0,  1'b0, 1'b0);
    step("t1_e2", 6'd2,  6'd1,  1'b0, 1'b0);
    step("t1_e3", 6'd4,  6'd2,  1'b0, 1'b0);
    step("t1_e4", 6'd8,  6'd4,  1'b0, 1'b0);
    step("t1_e5", 6'd16, 6'd8,  1'b0, 1'b0);
    step("t1_e6", 6'd32, 6'd16, 1'b0, 1'b0);
    step("t1_e7", 6'd1,  6'd32, 1'b1, 1'b0);
`ifdef STAGE_SEQ_PERF_EN
    check("perf_first_retire_cycles",  32'(bus.cycle_count),  32'd7);
    check("perf_first_retire_retires", 32'(bus.retire_count), 32'd1);
`endif
    step("t1_e8", 6'd2,  6'd1,  1'b0, 1'b0);

    // Skip READ/EXECUTE/MEMORY: decode jumps straight to WRITE_BACK.
    bus.skip_mask = 6'b011100;
    step("t2_e9",  6'd32, 6'd2,  1'b0, 1'b0);
    bus.skip_mask = 6'b000000;
    step("t2_e10", 6'd1,  6'd32, 1'b1, 1'b0);
    step("t2_e11", 6'd2,  6'd1,  1'b0, 1'b0);

    // Skip EXECUTE only; mask is captured at decode and held after input drops.
    bus.skip_mask = 6'b001000;
    step("hold_e12", 6'd4,  6'd2,  1'b0, 1'b0);
    bus.skip_mask = 6'b000000;
    step("hold_e13", 6'd16, 6'd4,  1'b0, 1'b0);
    step("hold_e14", 6'd32, 6'd16, 1'b0, 1'b0);
    step("hold_e15", 6'd1,  6'd32, 1'b1, 1'b0);
    step("hold_e16", 6'd2,  6'd1,  1'b0, 1'b0);
`ifdef STAGE_SEQ_PERF_EN
    check("perf_wrap_cycles", 32'(bus.cycle_count), 32'd0);
`endif
    step("hold_e17", 6'd4,  6'd2,  1'b0, 1'b0);

    // mem_wait in READ is ignored.
    bus.mem_wait = 1'b1;
    step("t4_e18", 6'd8,  6'd4,  1'b0, 1'b0);
    bus.mem_wait = 1'b0;
    step("t4_e19", 6'd16, 6'd8,  1'b0, 1'b0);

    // mem_wait 3 cycles in MEMORY: 4-cycle dwell, single enable pulse.
    bus.mem_wait = 1'b1;
    step("t3_e20", 6'd16, 6'd16, 1'b0, 1'b0);
    step("t3_e21", 6'd16, 6'd0,  1'b0, 1'b0);
    step("t3_e22", 6'd16, 6'd0,  1'b0, 1'b0);
    bus.mem_wait = 1'b0;
    step("t3_e23", 6'd32, 6'd0,  1'b0, 1'b0);
    step("t3_e24", 6'd1,  6'd32, 1'b1, 1'b0);

    // All-ones skip mask: decode goes straight to the last stage.
    step("ones_e25", 6'd2,  6'd1,  1'b0, 1'b0);
    bus.skip_mask = 6'b111111;
    step("ones_e26", 6'd32, 6'd2,  1'b0, 1'b0);
    bus.skip_mask = 6'b000000;
    step("ones_e27", 6'd1,  6'd32, 1'b1, 1'b0);

    // Reset mid-instruction drops the captured skip mask and pulses nothing.
    step("mid_e28", 6'd2, 6'd1, 1'b0, 1'b0);
    bus.skip_mask = 6'b001000;
    step("mid_e29", 6'd4, 6'd2, 1'b0, 1'b0);
    bus.skip_mask = 6'b000000;
    reset = 1'b1;
    step("mid_rst", 6'd0, 6'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step("mid_e31", 6'd1,  6'd0, 1'b0, 1'b0);
    step("mid_e32", 6'd2,  6'd1, 1'b0, 1'b0);
    step("mid_e33", 6'd4,  6'd2, 1'b0, 1'b0);
    step("mid_e34", 6'd8,  6'd4, 1'b0, 1'b0);
    step("mid_e35", 6'd16, 6'd8, 1'b0, 1'b0);

    // Fault together with mem_wait in MEMORY: halt wins and sticks.
    bus.mem_wait = 1'b1;
    bus.fault_in = 1'b1;
    step("t5_fault", 6'd0, 6'd0, 1'b0, 1'b1);
    bus.mem_wait = 1'b0;
    bus.fault_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step("t5_halt", 6'd0, 6'd0, 1'b0, 1'b1);
    end
    reset = 1'b1;
    step("t5_rst", 6'd0, 6'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step("t5_e1", 6'd1, 6'd0, 1'b0, 1'b0);
    step("t5_e2", 6'd2, 6'd1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
